// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, constants and FSM state type for the MIPS fetch path
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  DEFAULT_PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_WORD        = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ISSUED = 2'd2
    } seq_state_e;

    // Drop the byte offset so the PC always points at a whole word.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux (jump > branch > sequential) with alignment flag
module pc_next_sel
    import mips_pkg::*;
(
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic [ADDR_W-1:0] seq_addr_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              redirect_o,
    output logic              misalign_o
);

    // Pick the target; only the winning redirect target is checked for alignment.
    always_comb begin
        next_addr_o = seq_addr_i;
        redirect_o  = 1'b0;
        misalign_o  = 1'b0;
        if (jump_i) begin
            next_addr_o = word_align(jump_addr_i);
            redirect_o  = 1'b1;
            misalign_o  = (jump_addr_i[1:0] != 2'b00);
        end else if (branch_i) begin
            next_addr_o = word_align(branch_addr_i);
            redirect_o  = 1'b1;
            misalign_o  = (branch_addr_i[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch handshake FSM; DELAY_SLOT_EN enables the branch delay slot
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [3:0]         msb_pc4,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               misalign
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               misalign_q, misalign_d;

    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_redirect;
    logic               sel_misalign;

`ifdef DELAY_SLOT_EN
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
`endif

    assign pc_plus4    = pc_q + PC_STEP;
    assign msb_pc4     = pc_plus4[ADDR_W-1:ADDR_W-4];
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    // Decoded from the state register so an async reset drops the request at once.
    assign imem_req    = (state_q == REQ);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

    pc_next_sel u_next_sel (
        .jump_i        (jump),
        .jump_addr_i   (jump_addr),
        .branch_i      (branch),
        .branch_addr_i (branch_addr),
        .seq_addr_i    (pc_plus4),
        .next_addr_o   (sel_addr),
        .redirect_o    (sel_redirect),
        .misalign_o    (sel_misalign)
    );

    // Next-state logic: fetch in REQ, hold in ISSUED while stalled, advance PC on consume.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;
`ifdef DELAY_SLOT_EN
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUED;
                end
            end
            ISSUED: begin
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
`ifdef DELAY_SLOT_EN
                    // The slot instruction is leaving: follow the held target now.
                    // A redirect from the slot itself loses to the pending one.
                    if (pend_valid_q) begin
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        pc_d = pc_plus4;
                        if (sel_redirect) begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = sel_addr;
                            misalign_d   = misalign_q | sel_misalign;
                        end
                    end
`else
                    pc_d       = sel_addr;
                    misalign_d = misalign_q | sel_misalign;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, issued instruction and sticky misalign flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

`ifdef DELAY_SLOT_EN
    // Redirect target held across the delay slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= RESET_PC;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] jump_addr = '0;
    logic [31:0] branch_addr = '0;
    logic [31:0] imem_rdata = '0;
    logic [3:0]  msb_pc4;
    logic [31:0] pc, pc_plus4, imem_addr, instr;
    logic        imem_req, instr_valid, misalign;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .branch      (branch),
        .branch_addr (branch_addr),
        .msb_pc4     (msb_pc4),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .misalign    (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic        mis;
    } fetch_t;

    fetch_t      fetch_q[$];
    logic [31:0] instr_q[$];

    int total = 0;
    int bad = 0;

    // Reference model: program counter, sticky misalign, pending delay-slot target.
    logic [31:0] m_pc;
    logic        m_mis;
    logic        m_pend;
    logic [31:0] m_pend_addr;

    int ack_pct, stall_pct, redir_pct, valid_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFC;
            1: return 32'h0000_0102;
            2: return 32'h0040_0020;
            3: return $urandom;
            default: return $urandom & 32'h0000_FFFC;
        endcase
    endfunction

    // Instruction at m_pc leaves decode; work out the next fetch address.
    task automatic model_consume(input logic j, input logic [31:0] ja,
                                 input logic b, input logic [31:0] ba);
        logic [31:0] t;
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        t = j ? ja : ba;
`ifdef DELAY_SLOT_EN
        if (m_pend) begin
            m_pc   = m_pend_addr;
            m_pend = 1'b0;
        end else begin
            if (j || b) begin
                m_pend      = 1'b1;
                m_pend_addr = t - (t % 4);
                if (t % 4 != 0) m_mis = 1'b1;
            end
            m_pc = seq;
        end
`else
        if (j || b) begin
            m_pc = t - (t % 4);
            if (t % 4 != 0) m_mis = 1'b1;
        end else begin
            m_pc = seq;
        end
`endif
        fetch_q.push_back('{m_pc, m_mis});
    endtask

    // One cycle of stimulus, called just after a falling edge.
    task automatic step();
        imem_ack = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        jump_addr = $urandom;
        branch_addr = $urandom;
        if (imem_req && $urandom_range(0, 99) < ack_pct) begin
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            instr_q.push_back(imem_rdata);
        end
        if (instr_valid) begin
            valid_cycles++;
            jump = ($urandom_range(0, 99) < redir_pct);
            branch = ($urandom_range(0, 99) < redir_pct);
            jump_addr = pick_target();
            branch_addr = pick_target();
            stall = ($urandom_range(0, 99) < stall_pct);
            if (!stall) model_consume(jump, jump_addr, branch, branch_addr);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        fetch_q.delete();
        instr_q.delete();
        m_pc = RST_PC;
        m_mis = 1'b0;
        m_pend = 1'b0;
        m_pend_addr = RST_PC;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_instr", instr, 0);
        check("rst_misalign", misalign, 0);
        fetch_q.push_back('{RST_PC, 1'b0});
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_late_ack_valid", instr_valid, 0);
        imem_ack = 1'b0;
        reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a fetch starts or an instruction issues.
    initial begin : monitor
        logic   prev_req;
        logic   prev_valid;
        fetch_t cur;
        logic [31:0] cur_instr;
        prev_req = 1'b0;
        prev_valid = 1'b0;
        cur = '{RST_PC, 1'b0};
        cur_instr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                prev_req = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    if (fetch_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                    end else begin
                        cur = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, cur.addr);
                        check("misalign", {31'b0, misalign}, {31'b0, cur.mis});
                        check("pc_plus4", pc_plus4, cur.addr + 32'd4);
                        check("msb_pc4", {28'b0, msb_pc4}, (cur.addr + 32'd4) >> 28);
                    end
                end else if (imem_req) begin
                    check("fetch_addr_hold", imem_addr, cur.addr);
                end
                if (instr_valid && !prev_valid) begin
                    if (instr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL issue_unexpected: got instr %h expected no issue", instr);
                    end else begin
                        cur_instr = instr_q.pop_front();
                        check("issue_instr", instr, cur_instr);
                        check("issue_pc", pc, cur.addr);
                    end
                end else if (instr_valid) begin
                    check("stall_instr_hold", instr, cur_instr);
                    check("stall_pc_hold", pc, cur.addr);
                end
                prev_req = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    initial begin : driver
        bit found;
        #2;
        do_reset();

        // Same-cycle acks, no stall, no redirect: one issue every second cycle.
        ack_pct = 100; stall_pct = 0; redir_pct = 0; valid_cycles = 0;
        repeat (12) begin
            @(negedge clk);
            step();
        end
        check("throughput", valid_cycles, 6);

        ack_pct = 60; stall_pct = 30; redir_pct = 30; valid_cycles = 0;
        repeat (3000) begin
            @(negedge clk);
            step();
        end
        check("progress", {31'b0, valid_cycles > 200}, 1);

        // Reset while a fetch is outstanding.
        ack_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("req_found", {31'b0, found}, 1);
        check("no_lost_issue", instr_q.size(), 0);
        do_reset();

        ack_pct = 70; stall_pct = 20; redir_pct = 30;
        repeat (60) begin
            @(negedge clk);
            step();
        end
        ack_pct = 0; stall_pct = 0;
        repeat (5) begin
            @(negedge clk);
            step();
        end
        check("drain_instr_q", instr_q.size(), 0);
        check("drain_fetch_q", fetch_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
